// File: rtl/vlan_tag_classifier_if.sv
// vlan_tag_classifier_if: AXI-Stream bundle (tdata/tkeep/tuser/tlast/tvalid/tready)
interface vlan_tag_classifier_if #(
  parameter int DW = 64,
  parameter int UW = 4
);
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0] tuser;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master(output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave(input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/vlan_tag_classifier.sv
// vlan_tag_classifier: holds each packet head until the TPID field arrives, then releases it with a stable per-packet tag decision
module vlan_tag_classifier #(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_TUSER_WIDTH = 4,
  parameter int TAG_OFFSET = 12,
  parameter logic [15:0] TPID_VALUE = 16'h8100,
  parameter int TAG_SIZE_BYTES = 4,
  localparam int NUM_BUS_BYTES = AXIS_BUS_WIDTH / 8,
  localparam int DECIDE_BEAT = TAG_OFFSET / NUM_BUS_BYTES,
  localparam int BUF_DEPTH = DECIDE_BEAT + 2,
  localparam int SIZE_BITS = $clog2(TAG_SIZE_BYTES + 1)
) (
  input  logic aclk,
  input  logic areset,
  vlan_tag_classifier_if.slave axis_in,
  vlan_tag_classifier_if.master axis_out,
  output logic segment_sel,
  output logic [SIZE_BITS-1:0] segment_size
);
  localparam int LANE = TAG_OFFSET % NUM_BUS_BYTES;
  localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int BW = $clog2(DECIDE_BEAT + 2);
  localparam int EW = AXIS_BUS_WIDTH + NUM_BUS_BYTES + AXIS_TUSER_WIDTH + 1;
  if (TAG_OFFSET % 2 != 0 || LANE + 2 > NUM_BUS_BYTES) begin : g_bad_offset
    $error("vlan_tag_classifier: TAG_OFFSET odd or TPID field straddles a beat");
  end
  typedef enum logic {HEAD, BODY} state_t;
  state_t state, state_nx;
  logic [EW-1:0] mem [BUF_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [1:0] dmem, dcnt;
  logic dwr, drd;
  logic [BW-1:0] beat_idx;
  logic in_acc, out_acc, dec_pop, push_dec, dec_val, hit, at_decide;
  assign axis_in.tready = cnt != CW'(BUF_DEPTH) && dcnt != 2'd2;
  assign in_acc = axis_in.tvalid && axis_in.tready;
  assign axis_out.tvalid = cnt != '0 && dcnt != '0;
  assign out_acc = axis_out.tvalid && axis_out.tready;
  assign dec_pop = out_acc && axis_out.tlast;
  assign {axis_out.tdata, axis_out.tkeep, axis_out.tuser, axis_out.tlast} = mem[rd_ptr];
  assign at_decide = beat_idx == BW'(DECIDE_BEAT);
  assign hit = {axis_in.tdata[8*LANE +: 8], axis_in.tdata[8*(LANE+1) +: 8]} == TPID_VALUE && &axis_in.tkeep[LANE +: 2];
  assign push_dec = in_acc && state == HEAD && (at_decide || axis_in.tlast);
  assign dec_val = at_decide && hit;
  assign segment_sel = dcnt != '0 && dmem[drd];
  assign segment_size = segment_sel ? SIZE_BITS'(TAG_SIZE_BYTES) : '0;
  always_comb state_nx = !in_acc ? state : axis_in.tlast ? HEAD : state == HEAD && at_decide ? BODY : state;
  always_ff @(posedge aclk) state <= areset ? HEAD : state_nx;
  always_ff @(posedge aclk)
    if (areset) beat_idx <= '0;
    else if (in_acc) beat_idx <= axis_in.tlast ? '0 : beat_idx == BW'(DECIDE_BEAT + 1) ? beat_idx : beat_idx + 1'b1;
  always_ff @(posedge aclk)
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (in_acc) begin
        mem[wr_ptr] <= {axis_in.tdata, axis_in.tkeep, axis_in.tuser, axis_in.tlast};
        wr_ptr <= wr_ptr == PW'(BUF_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      end
      if (out_acc) rd_ptr <= rd_ptr == PW'(BUF_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + CW'(in_acc) - CW'(out_acc);
    end
  always_ff @(posedge aclk)
    if (areset) begin
      dmem <= '0;
      dwr <= 1'b0;
      drd <= 1'b0;
      dcnt <= '0;
    end else begin
      if (push_dec) begin
        dmem[dwr] <= dec_val;
        dwr <= ~dwr;
      end
      if (dec_pop) drd <= ~drd;
      dcnt <= dcnt + 2'(push_dec) - 2'(dec_pop);
    end
endmodule
